// File: rtl/mem_access_ctrl.sv
// Y86 memory-access stage: decodes icode into read/write/none, performs the access on an
// internal word RAM with configurable read latency and returns valM plus an address-error flag.
module mem_access_ctrl #(
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned DEPTH           = 256,
    parameter int unsigned RD_LAT          = 2,
    parameter int unsigned ERR_ON_MISALIGN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        icode_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [DATA_W-1:0] valA_i,
    input  logic [DATA_W-1:0] valP_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] valM_o,
    output logic              dmem_error_o,
    output logic              busy_o
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF   = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    // One extra bit so the limit never wraps for small DATA_W.
    localparam logic [DATA_W:0] LIMIT = (DATA_W+1)'(DEPTH) * (DATA_W+1)'(BYTES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] valm_q;
    logic              err_q;
    logic              out_valid_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              is_rd;
    logic              is_wr;
    logic              acc_err;
    logic              accept;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [IDX_W-1:0]  idx;

    always_comb begin
        is_rd = 1'b0;
        is_wr = 1'b0;
        addr  = valE_i;
        wdata = valA_i;
        case (icode_i)
            4'h5: is_rd = 1'b1;
            4'h4: is_wr = 1'b1;
            4'h8: begin
                is_wr = 1'b1;
                wdata = valP_i;
            end
            4'hA: is_wr = 1'b1;
            4'h9, 4'hB: begin
                is_rd = 1'b1;
                addr  = valA_i;
            end
            default: ;
        endcase
        acc_err = (is_rd || is_wr) &&
                  (({1'b0, addr} >= LIMIT) ||
                   ((ERR_ON_MISALIGN != 0) && (addr[OFF-1:0] != '0)));
    end

    assign idx          = addr[OFF+IDX_W-1:OFF];
    assign in_ready_o   = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign accept       = in_valid_i && in_ready_o;
    assign out_valid_o  = out_valid_q;
    assign valM_o       = valm_q;
    assign dmem_error_o = err_q;

    // Writes commit on the accepting edge, so a following read always sees them.
    always_ff @(posedge clk_i) begin
        if (accept && is_wr && !acc_err) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            valm_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        idx_q  <= idx;
                        valm_q <= '0;
                        err_q  <= acc_err;
                        if (is_rd && !acc_err) begin
                            state_q <= StWait;
                            cnt_q   <= 3'(RD_LAT - 1);
                        end else begin
                            state_q     <= StResp;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        valm_q      <= mem[idx_q];
                        state_q     <= StResp;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        valm_q      <= '0;
                        err_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: four instances cover the default configuration,
// ERR_ON_MISALIGN=0, RD_LAT=1 and RD_LAT=4.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [3:0]  icode     [4];
    logic [63:0] val_e     [4];
    logic [63:0] val_a     [4];
    logic [63:0] val_p     [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [63:0] val_m     [4];
    logic        derr      [4];
    logic        busy      [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: default, 1: misalign ignored, 2: RD_LAT=1, 3: RD_LAT=4
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned Lat = (g == 2) ? 1 : ((g == 3) ? 4 : 2);
        localparam int unsigned Mis = (g == 1) ? 0 : 1;
        mem_access_ctrl #(
            .DATA_W(64), .DEPTH(256), .RD_LAT(Lat), .ERR_ON_MISALIGN(Mis)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .icode_i     (icode[g]),
            .valE_i      (val_e[g]),
            .valA_i      (val_a[g]),
            .valP_i      (val_p[g]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .valM_o      (val_m[g]),
            .dmem_error_o(derr[g]),
            .busy_o      (busy[g])
        );
    end

    // Runs one transaction and reports latency (negedges from accept edge to valid), valM, err.
    task automatic xact(input int d, input logic [3:0] ic, input logic [63:0] e,
                        input logic [63:0] a, input logic [63:0] p,
                        output int lat, output logic [63:0] vm, output logic er);
        @(negedge clk);
        in_valid[d] = 1'b1;
        icode[d]    = ic;
        val_e[d]    = e;
        val_a[d]    = a;
        val_p[d]    = p;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        icode[d]    = 4'($urandom);
        val_e[d]    = {$urandom, $urandom};
        val_a[d]    = {$urandom, $urandom};
        val_p[d]    = {$urandom, $urandom};
        lat = 99;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (out_valid[d] === 1'b1) begin
                lat = i;
                break;
            end
        end
        vm = val_m[d];
        er = derr[d];
        if (lat != 99) begin
            out_ready[d] = 1'b1;
            @(posedge clk);
            #1;
            out_ready[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (out_valid[d] !== 1'b0 || val_m[d] !== 64'h0 || derr[d] !== 1'b0 ||
                busy[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state[%0d]: valid=%b valM=%h err=%b busy=%b ready=%b, want 0 0 0 0 1",
                         d, out_valid[d], val_m[d], derr[d], busy[d], in_ready[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rw();
        int lat; logic [63:0] vm; logic er;
        xact(0, 4'h4, 64'h40, 64'hDEAD, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 1 || vm !== 64'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL rmmov_40: lat=%0d valM=%h err=%b, want lat=1 valM=0 err=0", lat, vm, er);
        end
        xact(0, 4'h5, 64'h40, 64'h0, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 3 || vm !== 64'hDEAD || er !== 1'b0) begin
            errors++;
            $display("FAIL mrmov_40: lat=%0d valM=%h err=%b, want lat=3 valM=dead err=0", lat, vm, er);
        end
        xact(0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 1 || vm !== 64'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL no_access: lat=%0d valM=%h err=%b, want lat=1 valM=0 err=0", lat, vm, er);
        end
    endtask

    task automatic test_bounds();
        int lat; logic [63:0] vm; logic er;
        xact(0, 4'h4, 64'h7F8, 64'h1234, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL rmmov_last_word: lat=%0d err=%b, want lat=1 err=0", lat, er);
        end
        xact(0, 4'h5, 64'h800, 64'h0, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 1 || vm !== 64'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL mrmov_limit: lat=%0d valM=%h err=%b, want lat=1 valM=0 err=1", lat, vm, er);
        end
        xact(0, 4'h4, 64'h7FF8, 64'hBAD, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 1 || vm !== 64'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL rmmov_7ff8: lat=%0d valM=%h err=%b, want lat=1 valM=0 err=1", lat, vm, er);
        end
        xact(0, 4'h5, 64'h7F8, 64'h0, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 3 || vm !== 64'h1234 || er !== 1'b0) begin
            errors++;
            $display("FAIL word_ff_kept: lat=%0d valM=%h err=%b, want lat=3 valM=1234 err=0", lat, vm, er);
        end
    endtask

    task automatic test_misalign();
        int lat; logic [63:0] vm; logic er;
        xact(0, 4'h4, 64'h40, 64'h5555, 64'h0, lat, vm, er);
        xact(0, 4'h4, 64'h44, 64'h9999, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 1 || er !== 1'b1) begin
            errors++;
            $display("FAIL misalign_wr_err: lat=%0d err=%b, want lat=1 err=1", lat, er);
        end
        xact(0, 4'h5, 64'h40, 64'h0, 64'h0, lat, vm, er);
        checks++;
        if (vm !== 64'h5555 || er !== 1'b0) begin
            errors++;
            $display("FAIL misalign_no_write: valM=%h err=%b, want valM=5555 err=0", vm, er);
        end
        xact(0, 4'h5, 64'h41, 64'h0, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 1 || vm !== 64'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL misalign_rd_err: lat=%0d valM=%h err=%b, want lat=1 valM=0 err=1", lat, vm, er);
        end
        xact(1, 4'h4, 64'h44, 64'h9999, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL nomis_wr: lat=%0d err=%b, want lat=1 err=0", lat, er);
        end
        xact(1, 4'h5, 64'h40, 64'h0, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 3 || vm !== 64'h9999 || er !== 1'b0) begin
            errors++;
            $display("FAIL nomis_rd_word8: lat=%0d valM=%h err=%b, want lat=3 valM=9999 err=0", lat, vm, er);
        end
    endtask

    task automatic test_call_ret();
        int lat; logic [63:0] vm; logic er;
        xact(0, 4'h8, 64'h100, 64'h77, 64'h2A, lat, vm, er);
        xact(0, 4'h9, 64'h0, 64'h100, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 3 || vm !== 64'h2A || er !== 1'b0) begin
            errors++;
            $display("FAIL call_ret: lat=%0d valM=%h err=%b, want lat=3 valM=2a err=0", lat, vm, er);
        end
        xact(0, 4'hA, 64'h200, 64'hCAFE, 64'h99, lat, vm, er);
        xact(0, 4'hB, 64'h0, 64'h200, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 3 || vm !== 64'hCAFE || er !== 1'b0) begin
            errors++;
            $display("FAIL push_pop: lat=%0d valM=%h err=%b, want lat=3 valM=cafe err=0", lat, vm, er);
        end
    endtask

    task automatic test_stall();
        int lat; logic [63:0] vm; logic er;
        logic got = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b1; icode[0] = 4'h5; val_e[0] = 64'h40;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL stall_resp_seen: valid=%b, want 1", got);
        end
        // Offer a write while stalled; it must not be taken.
        in_valid[0] = 1'b1; icode[0] = 4'h4; val_a[0] = 64'h7777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid[0] !== 1'b1 || val_m[0] !== 64'h5555 || derr[0] !== 1'b0 ||
                in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b valM=%h err=%b ready=%b busy=%b, want 1 5555 0 0 1",
                         i, out_valid[0], val_m[0], derr[0], in_ready[0], busy[0]);
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: valid=%b ready=%b busy=%b, want 0 1 0",
                     out_valid[0], in_ready[0], busy[0]);
        end
        xact(0, 4'h5, 64'h40, 64'h0, 64'h0, lat, vm, er);
        checks++;
        if (vm !== 64'h5555) begin
            errors++;
            $display("FAIL stall_no_accept: valM=%h, want 5555", vm);
        end
    endtask

    task automatic test_latency();
        int lat; logic [63:0] vm; logic er;
        xact(2, 4'h4, 64'h10, 64'h11, 64'h0, lat, vm, er);
        xact(2, 4'h5, 64'h10, 64'h0, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 2 || vm !== 64'h11 || er !== 1'b0) begin
            errors++;
            $display("FAIL lat1_read: lat=%0d valM=%h err=%b, want lat=2 valM=11 err=0", lat, vm, er);
        end
        xact(3, 4'h4, 64'h10, 64'h44, 64'h0, lat, vm, er);
        xact(3, 4'h5, 64'h10, 64'h0, 64'h0, lat, vm, er);
        checks++;
        if (lat !== 5 || vm !== 64'h44 || er !== 1'b0) begin
            errors++;
            $display("FAIL lat4_read: lat=%0d valM=%h err=%b, want lat=5 valM=44 err=0", lat, vm, er);
        end
    endtask

    task automatic test_reset_mid(input int d);
        logic seen = 1'b0;
        @(negedge clk);
        in_valid[d] = 1'b1; icode[d] = 4'h5; val_e[d] = 64'h10;
        @(posedge clk);
        #1 in_valid[d] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait[%0d]: busy=%b valid=%b, want 1 0", d, busy[d], out_valid[d]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async[%0d]: valid=%b busy=%b ready=%b, want 0 0 1",
                     d, out_valid[d], busy[d], in_ready[d]);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid[d] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_resp[%0d]: response seen=%b, want 0", d, seen);
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            icode[d]     = 4'h0;
            val_e[d]     = '0;
            val_a[d]     = '0;
            val_p[d]     = '0;
        end
        test_reset();
        test_rw();
        test_bounds();
        test_misalign();
        test_call_ret();
        test_stall();
        test_latency();
        test_reset_mid(0);
        test_reset_mid(2);
        test_reset_mid(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
